// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback select and load extraction.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter (instret).
module wb_stage #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] RST_PC4 = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      WB_sel,
  input  logic [2:0]      load_funct3,
  input  logic [4:0]      rd_addr,
  input  logic            reg_wen,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_wen,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic            valid_q;
  logic            wen_q;
  logic [4:0]      rd_q;
  logic [1:0]      sel_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] mem_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] imm_q;

  // Flush only kills valid/wen; the payload fields load as normal since they are don't-care in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc4_q   <= RST_PC4;
      imm_q   <= '0;
    end else if (flush || !stall) begin
      valid_q <= flush ? 1'b0 : in_valid;
      wen_q   <= flush ? 1'b0 : reg_wen;
      rd_q    <= rd_addr;
      sel_q   <= WB_sel;
      f3_q    <= load_funct3;
      alu_q   <= alu_result;
      mem_q   <= mem_rdata;
      pc4_q   <= pc_plus4;
      imm_q   <= imm;
    end
  end

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic            misalign_raw;

  assign off = alu_q[1:0];

  always_comb begin
    ld_byte = mem_q[7:0];
    case (off)
      2'd0: ld_byte = mem_q[7:0];
      2'd1: ld_byte = mem_q[15:8];
      2'd2: ld_byte = mem_q[23:16];
      2'd3: ld_byte = mem_q[31:24];
      default: ld_byte = mem_q[7:0];
    endcase
    ld_half = off[1] ? mem_q[31:16] : mem_q[15:0];
  end

  always_comb begin
    ld_data      = mem_q;
    misalign_raw = 1'b0;
    case (f3_q)
      F3_LB:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data      = {{(XLEN-16){ld_half[15]}}, ld_half};
        misalign_raw = off[0];
      end
      F3_LHU: begin
        ld_data      = {{(XLEN-16){1'b0}}, ld_half};
        misalign_raw = off[0];
      end
      F3_LW: begin
        ld_data      = mem_q;
        misalign_raw = (off != 2'd0);
      end
      default: ld_data = mem_q;
    endcase
  end

  always_comb begin
    wb_data = imm_q;
    case (sel_q)
      SEL_MEM: wb_data = ld_data;
      SEL_ALU: wb_data = alu_q;
      SEL_PC4: wb_data = pc4_q;
      default: wb_data = imm_q;
    endcase
  end

  assign wb_valid    = valid_q;
  assign wb_rd       = rd_q;
  assign wb_misalign = valid_q && (sel_q == SEL_MEM) && misalign_raw;
  assign wb_wen      = valid_q && wen_q && (rd_q != 5'd0) && !wb_misalign;

`ifdef WB_RETIRE_CNT_EN
  // An entry retires on the edge it leaves the WB slot; held or faulting entries do not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (wb_valid && !stall && !wb_misalign) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage plus hand sequences for stall/flush/reset.
// Covers instret as well when built with WB_RETIRE_CNT_EN.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [1:0]  WB_sel;
  logic [2:0]  load_funct3;
  logic [4:0]  rd_addr;
  logic        reg_wen;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic        wb_misalign;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  wb_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .alu_result  (alu_result),
    .mem_rdata   (mem_rdata),
    .pc_plus4    (pc_plus4),
    .imm         (imm),
    .WB_sel      (WB_sel),
    .load_funct3 (load_funct3),
    .rd_addr     (rd_addr),
    .reg_wen     (reg_wen),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_wen      (wb_wen),
    .wb_data     (wb_data),
    .wb_misalign (wb_misalign)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret     (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic        e_valid;
    logic        e_wen;
    logic        e_mis;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] mem,
                              input logic [31:0] pc4, input logic [31:0] immv,
                              input logic [4:0] rd, input logic wen,
                              input logic e_valid, input logic e_wen, input logic e_mis,
                              input logic chk_data, input logic [31:0] e_data);
    vec_t t;
    t.v = v; t.sel = sel; t.f3 = f3; t.alu = alu; t.mem = mem; t.pc4 = pc4; t.imm = immv;
    t.rd = rd; t.wen = wen; t.e_valid = e_valid; t.e_wen = e_wen; t.e_mis = e_mis;
    t.chk_data = chk_data; t.e_data = e_data;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid    = t.v;
    WB_sel      = t.sel;
    load_funct3 = t.f3;
    alu_result  = t.alu;
    mem_rdata   = t.mem;
    pc_plus4    = t.pc4;
    imm         = t.imm;
    rd_addr     = t.rd;
    reg_wen     = t.wen;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] MW = 32'h80FF_7F01;

  initial begin
    vec_t t;
    // v sel f3 alu mem pc4 imm rd wen | valid wen mis chk data
    vecs.push_back(mk(1, 2'b01, 3'b000, 32'h0000_1234, 32'h0,  32'h0,         32'h0,         5'd5,  1, 1, 1, 0, 1, 32'h0000_1234));
    vecs.push_back(mk(1, 2'b00, 3'b000, 32'h0000_0003, MW,     32'h0,         32'h0,         5'd6,  1, 1, 1, 0, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 2'b00, 3'b100, 32'h0000_0001, MW,     32'h0,         32'h0,         5'd6,  1, 1, 1, 0, 1, 32'h0000_007F));
    vecs.push_back(mk(1, 2'b00, 3'b001, 32'h0000_0002, MW,     32'h0,         32'h0,         5'd6,  1, 1, 1, 0, 1, 32'hFFFF_80FF));
    vecs.push_back(mk(1, 2'b00, 3'b101, 32'h0000_0000, MW,     32'h0,         32'h0,         5'd6,  1, 1, 1, 0, 1, 32'h0000_7F01));
    vecs.push_back(mk(1, 2'b00, 3'b010, 32'h0000_1002, MW,     32'h0,         32'h0,         5'd7,  1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b10, 3'b000, 32'h0,         32'h0,  32'h0000_0040, 32'h0,         5'd0,  1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'b11, 3'b000, 32'h0,         32'h0,  32'h0,         32'hABCD_E000, 5'd7,  1, 1, 1, 0, 1, 32'hABCD_E000));
    vecs.push_back(mk(1, 2'b00, 3'b010, 32'h0000_1000, MW,     32'h0,         32'h0,         5'd8,  1, 1, 1, 0, 1, MW));
    vecs.push_back(mk(1, 2'b00, 3'b001, 32'h0000_0001, MW,     32'h0,         32'h0,         5'd8,  1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b00, 3'b000, 32'h0000_0000, MW,     32'h0,         32'h0,         5'd9,  1, 1, 1, 0, 1, 32'h0000_0001));
    vecs.push_back(mk(1, 2'b00, 3'b100, 32'h0000_0003, MW,     32'h0,         32'h0,         5'd9,  1, 1, 1, 0, 1, 32'h0000_0080));
    vecs.push_back(mk(1, 2'b00, 3'b011, 32'h0000_0002, MW,     32'h0,         32'h0,         5'd10, 1, 1, 1, 0, 1, MW));
    vecs.push_back(mk(1, 2'b00, 3'b101, 32'h0000_0003, MW,     32'h0,         32'h0,         5'd10, 1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2'b01, 3'b000, 32'h0000_5555, 32'h0,  32'h0,         32'h0,         5'd11, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 3'b000, 32'h0000_5555, 32'h0,  32'h0,         32'h0,         5'd11, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'b10, 3'b000, 32'h0,         32'h0,  32'h0000_0088, 32'h0,         5'd31, 1, 1, 1, 0, 1, 32'h0000_0088));

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    t = mk(0, 2'b00, 3'b000, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    drive(t);
    #12;
    chk("rst_valid", 0, 32'(wb_valid), 32'd0);
    chk("rst_wen", 0, 32'(wb_wen), 32'd0);
    chk("rst_rd", 0, 32'(wb_rd), 32'd0);
    chk("rst_mis", 0, 32'(wb_misalign), 32'd0);
    chk("rst_data", 0, wb_data, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_instret", 0, instret[31:0], 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk("valid", i, 32'(wb_valid), 32'(vecs[i].e_valid));
      chk("wen", i, 32'(wb_wen), 32'(vecs[i].e_wen));
      chk("mis", i, 32'(wb_misalign), 32'(vecs[i].e_mis));
      if (vecs[i].e_valid) chk("rd", i, 32'(wb_rd), 32'(vecs[i].rd));
      if (vecs[i].chk_data) chk("data", i, wb_data, vecs[i].e_data);
    end

    // JAL captured, then held by stall while upstream inputs keep changing.
    drive(mk(1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0104, 32'h0, 5'd1, 1, 0, 0, 0, 0, 0));
    tick();
    chk("jal_data", 0, wb_data, 32'h0000_0104);
    chk("jal_wen", 0, 32'(wb_wen), 32'd1);
    stall = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      drive(mk(1, 2'b01, 3'b000, 32'hDEAD_0000 + k, 32'h0, 32'h0000_0200, 32'h0, 5'd9, 1, 0, 0, 0, 0, 0));
      tick();
      chk("stall_data", k, wb_data, 32'h0000_0104);
      chk("stall_wen", k, 32'(wb_wen), 32'd1);
      chk("stall_rd", k, 32'(wb_rd), 32'd1);
    end
    flush = 1'b1;
    tick();
    chk("flst_valid", 0, 32'(wb_valid), 32'd0);
    chk("flst_wen", 0, 32'(wb_wen), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Flush alone on a valid incoming instruction.
    drive(mk(1, 2'b01, 3'b000, 32'h0000_0777, 32'h0, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0, 0, 0));
    tick();
    chk("pre_fl_wen", 0, 32'(wb_wen), 32'd1);
    flush = 1'b1;
    tick();
    chk("fl_valid", 0, 32'(wb_valid), 32'd0);
    chk("fl_wen", 0, 32'(wb_wen), 32'd0);
    flush = 1'b0;

    // Asynchronous reset between edges.
    drive(mk(1, 2'b01, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 5'd5, 1, 0, 0, 0, 0, 0));
    tick();
    chk("pre_rst_wen", 0, 32'(wb_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 0, 32'(wb_wen), 32'd0);
    chk("mid_rst_valid", 0, 32'(wb_valid), 32'd0);
    chk("mid_rst_rd", 0, 32'(wb_rd), 32'd0);
    chk("mid_rst_data", 0, wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef WB_RETIRE_CNT_EN
    // Ten instructions: #3 and #6 flushed, #8 misaligned, three stall cycles while #1 sits in WB.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8)
        drive(mk(1, 2'b00, 3'b010, 32'h0000_2001, MW, 32'h0, 32'h0, 5'd4, 1, 0, 0, 0, 0, 0));
      else
        drive(mk(1, 2'b01, 3'b000, 32'h0000_0100 + i, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0, 0, 0, 0, 0));
      flush = (i == 3 || i == 6);
      if (i == 2) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) tick();
        stall = 1'b0;
      end
      tick();
      flush = 1'b0;
    end
    drive(mk(0, 2'b01, 3'b000, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    chk("instret", 0, instret[31:0], 32'd7);
    chk("instret_hi", 0, instret[63:32], 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback result select. This is the return path that delivers results to the register file, complementing the operand path into the ALU.
- Captures the memory-stage bundle once per cycle. It selects among ALU result, load data, PC+4 and immediate.
- Performs load byte/halfword extraction with sign or zero extension, then drives the register-file write port.
- Sits between the data-memory stage and Reg[]. Its write port also feeds the forwarding logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RST_PC4, 32'h0000_0004, reset value of the registered PC+4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the pipeline register contents.
- flush  input  1  kill the entry being captured (insert a bubble).
- in_valid  input  1  memory stage holds a real instruction.
- alu_result  input  XLEN  ALU output; bits [1:0] give the load byte offset.
- mem_rdata  input  XLEN  raw aligned word from data memory.
- pc_plus4  input  XLEN  PC+4 for JAL/JALR link.
- imm  input  XLEN  immediate for LUI.
- WB_sel  input  2  00 mem, 01 alu, 10 pc+4, 11 imm.
- load_funct3  input  3  load type.
- rd_addr  input  5  destination register.
- reg_wen  input  1  instruction writes rd.
- wb_valid  output  1  registered valid.
- wb_rd  output  5  registered destination.
- wb_wen  output  1  register-file write enable.
- wb_data  output  XLEN  writeback value.
- wb_misalign  output  1  misaligned load in the WB slot.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All internal registers clear to 0, except the pc+4 register, which loads RST_PC4.
  - Outputs during reset: wb_valid=0, wb_wen=0, wb_rd=0, wb_misalign=0.
  - wb_data equals the selected value of the cleared registers, which is 0 with WB_sel=00.
  - Reset asserted mid-operation discards the held entry immediately, with no write.
- Capture at each rising clk edge, in priority order:
  - flush=1: valid register <= 0 and reg_wen register <= 0. Other fields may load or hold. Flush overrides stall.
  - Else stall=1: all registers hold.
  - Else: all inputs are registered.
- Latency: one register stage. wb_* outputs are combinational from the registered fields and are valid during the cycle after capture.
- Result select uses registered WB_sel: 00 load data (extended), 01 alu_result, 10 pc_plus4, 11 imm.
- Load extraction uses registered load_funct3 and off = registered alu_result[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1] (low or high), sign-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - 010 LW: full word.
  - Any other funct3: full word, no misalign.
  - Byte lanes are little-endian: byte k is mem_rdata[8k+7:8k].
- Misalignment:
  - wb_misalign=1 when valid & WB_sel==00 & either (LH/LHU and off[0]=1) or (LW and off!=0).
  - While wb_misalign=1, wb_wen is forced to 0. wb_data is still the extracted value and is don't-care for checking.
- Write enable: wb_wen = valid & reg_wen & (rd!=0) & !wb_misalign.
  - Writes to x0 are never issued.
  - When wb_wen=0, wb_data is don't-care for checking.
- Stalled entries: an entry held by stall keeps wb_wen asserted on every held cycle. Re-writing the same value is idempotent.
- Simultaneous flush and stall: flush wins, and the slot becomes a bubble on the next cycle.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret, 64 bits.
  - Asynchronously reset to 0.
  - Increments by 1 on each rising edge where wb_valid=1, stall=0 and wb_misalign=0.
  - Flushed bubbles, and stall cycles where the held entry is not advancing, do not count.
  - Wraps from 2^64-1 to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run:
  - Stimulus: with wb_wen=1, assert rst_n=0 between clock edges.
  - Response: wb_wen=0 and wb_valid=0 immediately, with no clock edge required; wb_rd=0.
- ALU path:
  - Stimulus: in_valid=1, WB_sel=01, alu_result=32'h0000_1234, rd=5, reg_wen=1.
  - Response: next cycle wb_wen=1, wb_rd=5, wb_data=32'h0000_1234.
- Load extension:
  - Stimulus: mem_rdata=32'h80FF_7F01 with WB_sel=00.
  - Response:
    - LB off=3 -> 32'hFFFF_FF80.
    - LBU off=1 -> 32'h0000_007F.
    - LH off=2 -> 32'hFFFF_80FF.
    - LHU off=0 -> 32'h0000_7F01.
- Misaligned and x0 writes:
  - Stimulus: LW with alu_result=32'h0000_1002.
  - Response: wb_misalign=1, wb_wen=0.
  - Stimulus: WB_sel=10 with rd=0, reg_wen=1.
  - Response: wb_wen=0.
- Stall and flush:
  - Stimulus: capture a JAL with pc_plus4=32'h0000_0104, rd=1; then stall=1 for 2 cycles while inputs change.
  - Response: wb_data stays 32'h0000_0104 and wb_wen=1 throughout.
  - Stimulus: then flush=1 together with stall=1.
  - Response: next cycle wb_valid=0, wb_wen=0.
- WB_RETIRE_CNT_EN:
  - Stimulus: 10 valid instructions including 2 flushed, 1 misaligned, and 3 stall cycles.
  - Response: instret=7.
